// File: rtl/huff_code_dict.sv
// Huffman code dictionary: 256-symbol load table with single-cycle lookups.
// Optional statistics counters are built when HUFF_DICT_STATS_EN is defined.
module huff_code_dict #(
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [7:0]         ld_char,
  input  logic [6:0]         ld_len,
  input  logic [MAX_LEN-1:0] ld_code,
  input  logic               ld_last,
  output logic               ld_err,
  output logic               dict_ready,
  input  logic               lk_valid,
  output logic               lk_ready,
  input  logic [7:0]         lk_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         char,
  output logic [6:0]         code_len,
  output logic [MAX_LEN-1:0] code,
  output logic               dict_err,
  output logic [8:0]         n_entries,
  output logic [15:0]        n_miss
);

  typedef enum logic {
    S_LOAD,
    S_READY
  } state_t;

  state_t state;
  state_t state_nx;

  logic               ld_fire;
  logic               lk_fire;
  logic               len_ok;
  logic               wr_en;
  logic               hit;
  logic [MAX_LEN-1:0] ld_mask;
  logic [255:0]       valid;

  logic [6:0]         mem_len  [256];
  logic [MAX_LEN-1:0] mem_code [256];

  assign ld_fire = ld_valid && ld_ready && !clear;
  assign lk_fire = lk_valid && lk_ready && !clear;
  assign len_ok  = (ld_len != 7'd0) && (ld_len <= 7'(MAX_LEN));
  assign wr_en   = ld_fire && len_ok;
  assign hit     = valid[lk_char];

  always_comb begin
    ld_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      ld_mask[i] = (i < int'(ld_len));
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_LOAD;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD:  if (ld_fire && ld_last) state_nx = S_READY;
      S_READY: state_nx = S_READY;
      default: state_nx = S_LOAD;
    endcase
    if (clear)
      state_nx = S_LOAD;
  end

  always_comb begin
    ld_ready   = 1'b0;
    dict_ready = 1'b0;
    lk_ready   = 1'b0;
    unique case (state)
      S_LOAD:  ld_ready = 1'b1;
      S_READY: begin
        dict_ready = 1'b1;
        lk_ready   = !out_valid || out_ready;
      end
      default: ;
    endcase
  end

  // Codes are stored pre-masked so lookups need no masking.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_len[ld_char]  <= ld_len;
      mem_code[ld_char] <= ld_code & ld_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid  <= '0;
      ld_err <= 1'b0;
    end else if (ld_fire) begin
      if (len_ok)
        valid[ld_char] <= 1'b1;
      else
        ld_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      char      <= '0;
      code_len  <= '0;
      code      <= '0;
      dict_err  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (lk_fire) begin
      out_valid <= 1'b1;
      char      <= lk_char;
      code_len  <= hit ? mem_len[lk_char] : 7'd0;
      code      <= hit ? mem_code[lk_char] : '0;
      dict_err  <= !hit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HUFF_DICT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      n_entries <= '0;
      n_miss    <= '0;
    end else begin
      if (wr_en && !valid[ld_char])
        n_entries <= n_entries + 9'd1;
      if (lk_fire && !hit && n_miss != 16'hFFFF)
        n_miss <= n_miss + 16'd1;
    end
  end
`else
  assign n_entries = '0;
  assign n_miss    = '0;
`endif

endmodule

// File: tb/tb_huff_code_dict.sv
// Self-checking bench for huff_code_dict: directed plan steps plus
// randomized load/lookup traffic against a dictionary/queue reference model.
module tb_huff_code_dict;

  localparam int MAX_LEN = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               ld_valid;
  logic               ld_ready;
  logic [7:0]         ld_char;
  logic [6:0]         ld_len;
  logic [MAX_LEN-1:0] ld_code;
  logic               ld_last;
  logic               ld_err;
  logic               dict_ready;
  logic               lk_valid;
  logic               lk_ready;
  logic [7:0]         lk_char;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         char;
  logic [6:0]         code_len;
  logic [MAX_LEN-1:0] code;
  logic               dict_err;
  logic [8:0]         n_entries;
  logic [15:0]        n_miss;

  huff_code_dict #(.MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_char    (ld_char),
    .ld_len     (ld_len),
    .ld_code    (ld_code),
    .ld_last    (ld_last),
    .ld_err     (ld_err),
    .dict_ready (dict_ready),
    .lk_valid   (lk_valid),
    .lk_ready   (lk_ready),
    .lk_char    (lk_char),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .char       (char),
    .code_len   (code_len),
    .code       (code),
    .dict_err   (dict_err),
    .n_entries  (n_entries),
    .n_miss     (n_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  c;
    logic [6:0]  l;
    logic [63:0] cd;
    logic        e;
  } res_t;

  int          n_chk = 0;
  int          n_fail = 0;

  bit          m_load;
  bit          m_valid [256];
  int          m_len   [256];
  logic [63:0] m_code  [256];
  bit          m_err;
  int          m_ne;
  int          m_nm;
  res_t        q [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_load = 1'b1;
    m_err  = 1'b0;
    m_ne   = 0;
    m_nm   = 0;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    q.delete();
  endtask

  task automatic chk_stats();
`ifdef HUFF_DICT_STATS_EN
    chk("n_entries", n_entries, m_ne);
    chk("n_miss", n_miss, m_nm);
`else
    chk("n_entries", n_entries, 0);
    chk("n_miss", n_miss, 0);
`endif
  endtask

  task automatic cycle();
    res_t r;
    bit ldf, lkf, pop;
    #1;
    chk("ld_ready", ld_ready, m_load);
    chk("dict_ready", dict_ready, !m_load);
    chk("lk_ready", lk_ready, !m_load && (q.size() == 0 || out_ready));
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_char", char, q[0].c);
      chk("out_len", code_len, q[0].l);
      chk("out_code", code, q[0].cd);
      chk("out_err", dict_err, q[0].e);
    end
    chk("ld_err", ld_err, m_err);
    chk_stats();
    ldf = ld_valid && m_load && !clear;
    lkf = lk_valid && !m_load && (q.size() == 0 || out_ready) && !clear;
    pop = q.size() != 0 && out_ready;
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else begin
      if (pop) void'(q.pop_front());
      if (lkf) begin
        r.c = lk_char;
        if (m_valid[lk_char]) begin
          r.l  = 7'(m_len[lk_char]);
          r.cd = m_code[lk_char];
          r.e  = 1'b0;
        end else begin
          r.l  = 7'd0;
          r.cd = 64'd0;
          r.e  = 1'b1;
          if (m_nm < 65535) m_nm++;
        end
        q.push_back(r);
      end
      if (ldf) begin
        if (ld_len >= 1 && int'(ld_len) <= MAX_LEN) begin
          if (!m_valid[ld_char]) m_ne++;
          m_valid[ld_char] = 1'b1;
          m_len[ld_char]   = int'(ld_len);
          m_code[ld_char]  = 64'(ld_code) & ((64'd1 << ld_len) - 64'd1);
        end else begin
          m_err = 1'b1;
        end
        if (ld_last) m_load = 1'b0;
      end
    end
    #1;
  endtask

  task automatic load(input logic [7:0] c, input logic [6:0] l,
                      input logic [MAX_LEN-1:0] cd, input logic last);
    ld_valid = 1'b1;
    ld_char  = c;
    ld_len   = l;
    ld_code  = cd;
    ld_last  = last;
    cycle();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic look(input logic [7:0] c);
    lk_valid = 1'b1;
    lk_char  = c;
    cycle();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic reset_checks();
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_dict_ready", dict_ready, 0);
    chk("rst_lk_ready", lk_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_char", char, 0);
    chk("rst_code_len", code_len, 0);
    chk("rst_code", code, 0);
    chk("rst_dict_err", dict_err, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_n_entries", n_entries, 0);
    chk("rst_n_miss", n_miss, 0);
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    ld_valid = 1'b0;
    ld_char = '0;
    ld_len = '0;
    ld_code = '0;
    ld_last = 1'b0;
    lk_valid = 1'b0;
    lk_char = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    reset_checks();

    // Basic load and back-to-back lookups
    load(8'h41, 7'd2, 32'h2, 1'b0);
    load(8'h42, 7'd3, 32'h3, 1'b1);
    look(8'h41);
    chk("t1_a_len", code_len, 2);
    chk("t1_a_code", code, 2);
    chk("t1_a_err", dict_err, 0);
    look(8'h42);
    chk("t1_b_len", code_len, 3);
    chk("t1_b_code", code, 3);
    chk("t1_b_err", dict_err, 0);
    look(8'h43);
    lk_valid = 1'b0;
    chk("t1_c_len", code_len, 0);
    chk("t1_c_code", code, 0);
    chk("t1_c_err", dict_err, 1);
`ifdef HUFF_DICT_STATS_EN
    chk("t1_n_entries", n_entries, 2);
    chk("t1_n_miss", n_miss, 1);
`endif
    cycle();

    // Illegal lengths rejected, upper code bits masked
    do_clear();
    load(8'h41, 7'd0, 32'h1, 1'b0);
    load(8'h41, 7'd40, 32'h7, 1'b0);
    load(8'h41, 7'd5, 32'hFFFF_FFFF, 1'b1);
    chk("t2_ld_err", ld_err, 1);
    look(8'h41);
    lk_valid = 1'b0;
    chk("t2_len", code_len, 5);
    chk("t2_code", code, 32'h1F);
    cycle();

    // Duplicate load: last wins
    do_clear();
    load(8'h5A, 7'd4, 32'h5, 1'b0);
    load(8'h5A, 7'd6, 32'h2A, 1'b1);
    look(8'h5A);
    lk_valid = 1'b0;
    chk("t3_len", code_len, 6);
    chk("t3_code", code, 32'h2A);
`ifdef HUFF_DICT_STATS_EN
    chk("t3_n_entries", n_entries, 1);
`endif
    cycle();

    // Back-pressure for three cycles
    out_ready = 1'b0;
    look(8'h5A);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_lk_ready_stall", lk_ready, 0);
      look(8'h51);
    end
    out_ready = 1'b1;
    look(8'h51);
    lk_valid = 1'b0;
    repeat (2) cycle();

    // clear wins over ld_last
    do_clear();
    load(8'h4D, 7'd3, 32'h5, 1'b0);
    load(8'h4E, 7'd2, 32'h1, 1'b0);
    clear = 1'b1;
    load(8'h50, 7'd4, 32'h9, 1'b1);
    clear = 1'b0;
    chk("t5_dict_ready", dict_ready, 0);
    chk("t5_ld_ready", ld_ready, 1);
    load(8'h58, 7'd1, 32'h1, 1'b1);
    look(8'h4D);
    chk("t5_m_err", dict_err, 1);
    look(8'h4E);
    look(8'h50);
    look(8'h58);
    lk_valid = 1'b0;
    chk("t5_x_len", code_len, 1);
    cycle();

    // Randomized load and lookup traffic
    do_clear();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) cycle();
      load(8'($urandom_range(0, 63)), 7'($urandom_range(0, 40)),
           32'($urandom), i == 39);
    end
    for (int i = 0; i < 300; i++) begin
      lk_valid  = ($urandom_range(0, 3) != 0);
      lk_char   = 8'($urandom_range(0, 80));
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    lk_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) cycle();

    // Reset mid-stream with a result pending
    out_ready = 1'b0;
    look(8'h05);
    lk_valid = 1'b0;
    chk("t6_pre_out_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    model_reset();
    #1;
    reset_checks();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/huff_code_dict.md
# huff_code_dict

Code dictionary for the Huffman encode path. It is loaded once per stream with one (character, code length, code bits) entry per symbol, then serves single-cycle-throughput lookups for the byte fetch and serializer stages. For every looked-up byte it returns `code_len`, the right-aligned code word and `dict_err`. It sits directly upstream of the encode block, driving its `dict_ready`, `code_len` and `dict_err` inputs.

## Interface
- `MAX_LEN`, default 32: widest code word supported, in bits (1..127).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `clear` in 1: discard the current dictionary and return to loading.
- `ld_valid` in 1: a load entry is presented.
- `ld_ready` out 1: entry accepted when `ld_valid && ld_ready`.
- `ld_char` in 8: symbol being defined.
- `ld_len` in 7: code length in bits.
- `ld_code` in MAX_LEN: code word, right-aligned; bits at and above `ld_len` are ignored.
- `ld_last` in 1: marks the final entry of the dictionary.
- `ld_err` out 1: sticky; set when an entry with illegal length was rejected.
- `dict_ready` out 1: dictionary complete; lookups allowed.
- `lk_valid` in 1, `lk_ready` out 1, `lk_char` in 8: lookup request handshake.
- `out_valid` out 1, `out_ready` in 1: lookup result handshake.
- `char` out 8: echoed `lk_char`.
- `code_len` out 7: code length of `char`; 0 on miss.
- `code` out MAX_LEN: code word, right-aligned, bits ≥ `code_len` zero.
- `dict_err` out 1: result is a miss (`char` has no entry).
- `n_entries` out 9: number of distinct valid characters.
- `n_miss` out 16: miss count, saturating.

## Operation
- Storage: 256 × (7 + MAX_LEN) entry array plus a 256-bit valid bitmap.
  - Bitmap is cleared in one cycle on `rst` or `clear`.
  - Array contents are don't-care while the matching valid bit is 0.
- State LOAD, entered on reset and on `clear`:
  - `ld_ready`=1, `lk_ready`=0, `dict_ready`=0.
  - An accepted entry with 1 ≤ `ld_len` ≤ MAX_LEN writes the array and sets the valid bit.
  - A duplicate `ld_char` overwrites the earlier entry (last wins).
  - `ld_len`=0 or `ld_len` > MAX_LEN: no write, `ld_err` set.
  - An accepted entry with `ld_last`=1 is processed normally, then the block moves to READY.
- State READY:
  - `ld_ready`=0, `dict_ready`=1, `lk_ready` = !`out_valid` || `out_ready`.
  - An accepted lookup registers its result into the output stage. Hit: stored len/code with upper bits masked, `dict_err`=0. Miss: len 0, code 0, `dict_err`=1.
  - The output stage holds all fields stable while `out_valid && !out_ready`.
- `clear` in any state:
  - Next state LOAD, bitmap cleared, `ld_err` cleared, `out_valid` dropped.
  - Any same-cycle load or lookup is discarded.
  - `clear` has priority over `ld_last`.
- `rst` has the same effect as `clear`, and additionally zeroes every output register.

## Timing
- Reset values:
  - `ld_ready`=1, `dict_ready`=0, `lk_ready`=0, `out_valid`=0.
  - `char`, `code_len`, `code`, `dict_err`, `ld_err`, `n_entries`, `n_miss` all 0.
- Loading: one entry per cycle. `ld_last` accepted in cycle N gives `dict_ready`=1 and `lk_ready`=1 in cycle N+1.
- Lookup latency: accepted in cycle N, result valid in cycle N+1. Sustained throughput is 1 per cycle while `out_ready`=1.
- Back-pressure: with `out_ready`=0 and `out_valid`=1, `lk_ready`=0 in the same cycle, combinationally from `out_ready`. There is no skid buffer.
- `clear` in cycle N gives LOAD and `out_valid`=0 in cycle N+1.

## Configuration
- `HUFF_DICT_STATS_EN` defined:
  - `n_entries` counts valid-bit 0→1 transitions; it is not incremented on overwrite and reaches at most 256.
  - `n_miss` increments per accepted lookup that misses and saturates at 65535.
  - Both counters clear on `rst` and on `clear`.
- Not defined: both ports are tied to 0 and no counter logic is synthesized.

## Test plan
- Load 'A'(len 2, code 0b10) and 'B'(len 3, code 0b011, `ld_last`); look up 'A','B','C' back-to-back:
  - Results 2/0x2/err0, then 3/0x3/err0, then 0/0/err1 on consecutive cycles.
  - With stats enabled: `n_entries`=2, `n_miss`=1.
- Load 'A' with len 0, then 'A' with len 40 (MAX_LEN 32), then 'A' with len 5, code 0xFFFF_FFFF:
  - `ld_err`=1; lookup of 'A' returns len 5, code 0x1F.
- Duplicate load 'Z' (len 4, code 0x5), then 'Z' (len 6, code 0x2A):
  - Lookup returns 6/0x2A; `n_entries`=1.
- Hold `out_ready`=0 for 3 cycles with `lk_valid`=1:
  - `lk_ready`=0 throughout, output fields stable.
  - After `out_ready` rises, no result is lost or duplicated.
- Assert `clear` in the same cycle as `ld_last`:
  - Block stays in LOAD, `dict_ready`=0, every earlier entry looks up as a miss after reload.
- Assert `rst` mid-stream with `out_valid`=1:
  - All outputs are at their reset values the next cycle, `ld_ready`=1.
